irq_source_ctrl: RTL and testbench
==================================

// Module: irq_source_ctrl
// PURPOSE
//  Interrupt source controller on the requesting side of the core's irq/irq_ack, eret_ack handshake.
//  Latches rising edges from NUM_SRC peripheral lines, selects the highest-priority enabled source,
//  drives irq/irq_id until the core's injection logic acks, then tracks the active interrupt until eret_ack.
//  Sits between the peripheral bus (sources, mask CSR) and the cpu top; lower index = higher priority.
// PARAMETERS
//  NUM_SRC     8   number of interrupt source lines (2..32)
//  IDW         3   width of source id, must equal $clog2(NUM_SRC)
//  NEST_DEPTH  4   active-id stack depth, used only with IRQ_NESTING_EN (1..8)
// PORTS
//  clk            in   1        core clock
//  rst            in   1        asynchronous, active-high reset
//  src_irq        in   NUM_SRC  peripheral interrupt lines, synchronous to clk, rising-edge significant
//  src_mask       in   NUM_SRC  1 = source enabled for request; masked sources still latch pending
//  irq_ack        in   1        core has taken the request (level; valid only in REQ)
//  eret_ack       in   1        core has completed return-from-interrupt injection
//  irq            out  1        interrupt request to core (registered)
//  irq_id         out  IDW      id of requested source, stable while irq=1
//  active_id      out  IDW      id currently in service (top of stack); 0 when none
//  in_service     out  1        1 while at least one interrupt is active
//  pending        out  NUM_SRC  latched pending bits
//  spurious_eret  out  1        1-cycle pulse: eret_ack seen with nothing in service
// BEHAVIOUR
//  Reset (async): irq=0, irq_id=0, active_id=0, in_service=0, pending=0, spurious_eret=0, depth=0,
//   src_q=0, state=IDLE. A line already high at reset release counts as an edge on the first clk.
//  Edge detect: rise = src_irq & ~src_q; pending <= (pending & ~clr) | rise; set wins over clr on the same bit.
//  Candidate: lowest index i with pending[i] & src_mask[i]; cand_vld = |(pending & src_mask).
//  Latency: line rises before edge N -> pending set at N -> irq=1, irq_id valid after edge N+1.
//  FSM states IDLE, REQ, SERVICE:
//   IDLE: cand_vld -> irq<=1, irq_id<=cand, REQ. Otherwise stay.
//   REQ: irq and irq_id held. Mask changes do not retract irq.
//     irq_ack=1 -> irq<=0; clr pending[irq_id]; push irq_id; in_service<=1; SERVICE.
//     irq dropping on the ack edge is mandatory: the core re-samples irq in its idle state.
//   SERVICE: eret_ack=1 -> pop. If depth becomes 0 -> in_service<=0, active_id<=0, IDLE.
//     Otherwise stay in SERVICE; active_id<=new top.
//  eret_ack in IDLE -> spurious_eret pulse, no other effect. irq_ack outside REQ is ignored.
//  eret_ack in REQ (only reachable when nested) pops; irq stays asserted.
//   Pop empties the stack -> in_service<=0, stay REQ.
//  irq_ack and eret_ack together in REQ: pop first, then push; net depth unchanged, top = irq_id.
//  depth counter never underflows/overflows; pop at depth 0 = spurious_eret; push at NEST_DEPTH cannot occur.
// CONFIGURATION
//  IRQ_NESTING_EN defined: in SERVICE, cand_vld & (cand < active_id) & (depth < NEST_DEPTH)
//   -> irq<=1, irq_id<=cand, REQ. Stack holds up to NEST_DEPTH ids.
//  IRQ_NESTING_EN undefined: SERVICE never raises irq; new events stay pending until IDLE.
//   Stack degenerates to one register; depth max 1; NEST_DEPTH ignored.
// TESTING
//  T1 reset: assert rst mid-REQ with irq=1 -> all outputs 0 same cycle; pending=0 after release.
//  T2 basic: mask=8'hFF, pulse src_irq[5] -> irq=1, irq_id=5 two edges later.
//   irq_ack 1 cycle -> irq=0 next edge, in_service=1, active_id=5.
//   eret_ack -> in_service=0, IDLE.
//  T3 priority/mask: src 2 and 6 rise same cycle, mask=8'hFB -> irq_id=6; pending[2] stays 1.
//   After eret_ack, unmask bit 2 -> irq_id=2.
//  T4 edge during ack: src_irq[3] re-rises on the irq_ack edge for id 3 -> pending[3]=1 after edge.
//   Second request for id 3 follows the eret_ack.
//  T5 spurious: eret_ack in IDLE -> spurious_eret=1 for exactly 1 cycle; state and depth unchanged.
//  T6 nesting (IRQ_NESTING_EN): service id 4, raise src 1 -> irq_id=1 while in_service=1.
//   ack -> active_id=1; eret_ack -> active_id=4; eret_ack -> IDLE.
//   Raising src 6 while active=4 -> no irq. Without macro, src 1 waits until IDLE.

Source files
------------

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl
//   Interrupt source controller on the requesting side of the core's
//   irq/irq_ack and eret_ack handshake. It latches rising edges on the
//   peripheral lines as pending bits and picks the lowest-index pending,
//   enabled source. It drives irq/irq_id until the core acks, then keeps
//   the id on an active stack until eret_ack pops it.
//
//   Optional feature macro: IRQ_NESTING_EN
//     defined   : a higher-priority source preempts while in service
//                 (stack of NEST_DEPTH ids)
//     undefined : one active id; new requests wait until idle
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   src_irq        peripheral interrupt lines (rising-edge significant)
//   src_mask       per-source request enable (pending still latches)
//   irq_ack        core has taken the request (honoured only in REQ)
//   eret_ack       core has completed return-from-interrupt
//   irq, irq_id    registered request and id of the requested source
//   active_id      id at top of the active stack, 0 when none
//   in_service     at least one interrupt active
//   pending        latched pending bits
//   spurious_eret  one-cycle pulse when eret_ack has nothing to pop
module irq_source_ctrl #(
  parameter int unsigned NUM_SRC    = 8,
  parameter int unsigned IDW        = 3,
  parameter int unsigned NEST_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               irq_ack,
  input  logic               eret_ack,
  output logic               irq,
  output logic [IDW-1:0]     irq_id,
  output logic [IDW-1:0]     active_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic               spurious_eret
);

`ifdef IRQ_NESTING_EN
  localparam int unsigned STK = NEST_DEPTH;
`else
  // Without nesting the stack is a single slot.
  localparam int unsigned STK = (NEST_DEPTH < 1) ? NEST_DEPTH : 1;
`endif
  localparam int unsigned DW = $clog2(STK + 1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] rise, clr, cand_vec;
  logic [IDW-1:0]     irq_id_q, irq_id_d;
  logic [IDW-1:0]     cand, top;
  logic               irq_q, irq_d;
  logic               spur_q, spur_d;
  logic               cand_vld, push, pop;
  logic [DW-1:0]      depth_q, depth_d, depth_pop;
  logic [IDW-1:0]     stack_q [STK];
  logic [IDW-1:0]     stack_d [STK];

  // Edge detect and priority select.
  always_comb begin
    src_d    = src_irq;
    rise     = src_irq & ~src_q;
    cand_vec = pending_q & src_mask;
    cand_vld = |cand_vec;
    cand     = '0;
    // Walk downward so the lowest set index is the one left in cand.
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (cand_vec[i-1]) cand = IDW'(i - 1);
    end
  end

  // Top of the active stack.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < STK; i++) begin
      if (depth_q == DW'(i + 1)) top = stack_q[i];
    end
  end

  // Request / service FSM.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    push     = 1'b0;
    pop      = 1'b0;
    spur_d   = 1'b0;
    clr      = '0;
    unique case (state_q)
      IDLE: begin
        if (eret_ack) spur_d = 1'b1;
        if (cand_vld) begin
          irq_d    = 1'b1;
          irq_id_d = cand;
          state_d  = REQ;
        end
      end
      REQ: begin
        // A pop happens before the push when both acks arrive together.
        if (eret_ack) begin
          if (depth_q != '0) pop = 1'b1;
          else               spur_d = 1'b1;
        end
        if (irq_ack) begin
          irq_d   = 1'b0;
          clr     = NUM_SRC'(1) << irq_id_q;
          push    = 1'b1;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (eret_ack) begin
          pop = 1'b1;
          if (depth_q == DW'(1)) state_d = IDLE;
        end
`ifdef IRQ_NESTING_EN
        else if (cand_vld && (cand < top) && (depth_q < DW'(STK))) begin
          irq_d    = 1'b1;
          irq_id_d = cand;
          state_d  = REQ;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending bits and stack update; a new edge wins over the ack clear.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    depth_pop = pop ? (depth_q - DW'(1)) : depth_q;
    depth_d   = push ? (depth_pop + DW'(1)) : depth_pop;
    stack_d   = stack_q;
    for (int unsigned i = 0; i < STK; i++) begin
      if (push && (depth_pop == DW'(i))) stack_d[i] = irq_id_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      spur_q    <= 1'b0;
      depth_q   <= '0;
      for (int unsigned i = 0; i < STK; i++) stack_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      spur_q    <= spur_d;
      depth_q   <= depth_d;
      stack_q   <= stack_d;
    end
  end

  assign irq           = irq_q;
  assign irq_id        = irq_id_q;
  assign active_id     = top;
  assign in_service    = (depth_q != '0);
  assign pending       = pending_q;
  assign spurious_eret = spur_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
module tb_irq_source_ctrl;

`ifdef IRQ_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_irq, src_mask, pending;
  logic       irq_ack, eret_ack, irq, in_service, spurious_eret;
  logic [2:0] irq_id, active_id;

  irq_source_ctrl #(.NUM_SRC(8), .IDW(3), .NEST_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .src_irq(src_irq), .src_mask(src_mask),
    .irq_ack(irq_ack), .eret_ack(eret_ack), .irq(irq), .irq_id(irq_id),
    .active_id(active_id), .in_service(in_service), .pending(pending),
    .spurious_eret(spurious_eret)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending set, a queue of active ids, request flag.
  logic [7:0] m_src_q, m_pend;
  bit         m_irq, m_spur;
  int         m_id;
  int         m_stk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_src_q = '0; m_pend = '0; m_irq = 0; m_spur = 0; m_id = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input logic [7:0] s, input logic [7:0] m, input logic a, input logic e);
    logic [7:0] rise, clr, cv;
    int cand;
    rise = s & ~m_src_q;
    clr  = '0;
    cv   = m_pend & m;
    cand = -1;
    for (int i = 0; i < 8; i++) if (cv[i] && cand < 0) cand = i;
    m_spur = 0;
    if (m_irq) begin
      if (e) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else m_spur = 1;
      end
      if (a) begin
        clr[m_id] = 1'b1;
        m_stk.push_back(m_id);
        m_irq = 0;
      end
    end else if (m_stk.size() > 0) begin
      if (e) void'(m_stk.pop_back());
      else if (NEST && cand >= 0 && cand < m_stk[$] && m_stk.size() < 4) begin
        m_irq = 1; m_id = cand;
      end
    end else begin
      if (e) m_spur = 1;
      if (cand >= 0) begin m_irq = 1; m_id = cand; end
    end
    m_pend  = (m_pend & ~clr) | rise;
    m_src_q = s;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".irq"},        32'(irq),           32'(m_irq));
    chk({tag, ".irq_id"},     32'(irq_id),        32'(m_id));
    chk({tag, ".active_id"},  32'(active_id),     (m_stk.size() > 0) ? m_stk[$] : 0);
    chk({tag, ".in_service"}, 32'(in_service),    32'(m_stk.size() > 0));
    chk({tag, ".pending"},    32'(pending),       32'(m_pend));
    chk({tag, ".spurious"},   32'(spurious_eret), 32'(m_spur));
  endtask

  // Inputs driven at the falling edge, outputs checked at the next falling edge.
  task automatic cyc(input logic [7:0] s, input logic [7:0] m, input logic a, input logic e);
    src_irq = s; src_mask = m; irq_ack = a; eret_ack = e;
    @(posedge clk);
    model_step(s, m, a, e);
    @(negedge clk);
    check_model("model");
  endtask

  typedef struct {
    logic [7:0] s, m;
    logic       a, e;
    logic       x_irq;
    logic [2:0] x_id;
    logic       x_ins;
    logic [2:0] x_act;
    logic       x_spur;
    logic [7:0] x_pend;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // basic request / ack / eret on source 5
    tbl[0]  = '{8'h20, 8'hFF, 0, 0, 0, 3'd0, 0, 3'd0, 0, 8'h20};
    tbl[1]  = '{8'h00, 8'hFF, 0, 0, 1, 3'd5, 0, 3'd0, 0, 8'h20};
    tbl[2]  = '{8'h00, 8'hFF, 1, 0, 0, 3'd5, 1, 3'd5, 0, 8'h00};
    tbl[3]  = '{8'h00, 8'hFF, 0, 0, 0, 3'd5, 1, 3'd5, 0, 8'h00};
    tbl[4]  = '{8'h00, 8'hFF, 0, 1, 0, 3'd5, 0, 3'd0, 0, 8'h00};
    // spurious eret in idle, one-cycle pulse
    tbl[5]  = '{8'h00, 8'hFF, 0, 1, 0, 3'd5, 0, 3'd0, 1, 8'h00};
    tbl[6]  = '{8'h00, 8'hFF, 0, 0, 0, 3'd5, 0, 3'd0, 0, 8'h00};
    // priority with source 2 masked
    tbl[7]  = '{8'h44, 8'hFB, 0, 0, 0, 3'd5, 0, 3'd0, 0, 8'h44};
    tbl[8]  = '{8'h00, 8'hFB, 0, 0, 1, 3'd6, 0, 3'd0, 0, 8'h44};
    tbl[9]  = '{8'h00, 8'hFB, 1, 0, 0, 3'd6, 1, 3'd6, 0, 8'h04};
    tbl[10] = '{8'h00, 8'hFB, 0, 1, 0, 3'd6, 0, 3'd0, 0, 8'h04};
    tbl[11] = '{8'h00, 8'hFF, 0, 0, 1, 3'd2, 0, 3'd0, 0, 8'h04};
    tbl[12] = '{8'h00, 8'hFF, 1, 0, 0, 3'd2, 1, 3'd2, 0, 8'h00};
    tbl[13] = '{8'h00, 8'hFF, 0, 1, 0, 3'd2, 0, 3'd0, 0, 8'h00};

    rst = 1'b1; src_irq = '0; src_mask = '0; irq_ack = 0; eret_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].s, tbl[i].m, tbl[i].a, tbl[i].e);
      chk($sformatf("tbl%0d.irq", i),     32'(irq),           32'(tbl[i].x_irq));
      chk($sformatf("tbl%0d.irq_id", i),  32'(irq_id),        32'(tbl[i].x_id));
      chk($sformatf("tbl%0d.in_svc", i),  32'(in_service),    32'(tbl[i].x_ins));
      chk($sformatf("tbl%0d.active", i),  32'(active_id),     32'(tbl[i].x_act));
      chk($sformatf("tbl%0d.spur", i),    32'(spurious_eret), 32'(tbl[i].x_spur));
      chk($sformatf("tbl%0d.pending", i), 32'(pending),       32'(tbl[i].x_pend));
    end

    // Asynchronous reset while a request is outstanding.
    cyc(8'h80, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t1.req_irq", 32'(irq), 32'd1);
    chk("t1.req_id", 32'(irq_id), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("t1.irq", 32'(irq), 32'd0);
    chk("t1.irq_id", 32'(irq_id), 32'd0);
    chk("t1.active", 32'(active_id), 32'd0);
    chk("t1.in_svc", 32'(in_service), 32'd0);
    chk("t1.pending", 32'(pending), 32'd0);
    chk("t1.spur", 32'(spurious_eret), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t1.pend_after", 32'(pending), 32'd0);

    // Source re-rises on its own ack edge.
    cyc(8'h08, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t4.id", 32'(irq_id), 32'd3);
    cyc(8'h08, 8'hFF, 1, 0);
    chk("t4.pend3", 32'(pending[3]), 32'd1);
    chk("t4.irq_drop", 32'(irq), 32'd0);
    cyc(8'h00, 8'hFF, 0, 1);
    chk("t4.idle", 32'(in_service), 32'd0);
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t4.rereq", 32'(irq), 32'd1);
    chk("t4.rereq_id", 32'(irq_id), 32'd3);
    cyc(8'h00, 8'hFF, 1, 0);
    cyc(8'h00, 8'hFF, 0, 1);

    // Nesting behaviour while id 4 is in service.
    cyc(8'h10, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t6.id4", 32'(irq_id), 32'd4);
    cyc(8'h00, 8'hFF, 1, 0);
    chk("t6.act4", 32'(active_id), 32'd4);
    cyc(8'h40, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t6.no_low", 32'(irq), 32'd0);
    cyc(8'h02, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
`ifdef IRQ_NESTING_EN
    chk("t6.nest_irq", 32'(irq), 32'd1);
    chk("t6.nest_id", 32'(irq_id), 32'd1);
    chk("t6.nest_ins", 32'(in_service), 32'd1);
    cyc(8'h00, 8'hFF, 1, 0);
    chk("t6.act1", 32'(active_id), 32'd1);
    cyc(8'h00, 8'hFF, 0, 1);
    chk("t6.back4", 32'(active_id), 32'd4);
    chk("t6.still_ins", 32'(in_service), 32'd1);
    cyc(8'h00, 8'hFF, 0, 1);
    chk("t6.done", 32'(in_service), 32'd0);
`else
    chk("t6.wait_irq", 32'(irq), 32'd0);
    chk("t6.wait_ins", 32'(in_service), 32'd1);
    cyc(8'h00, 8'hFF, 0, 1);
    chk("t6.done", 32'(in_service), 32'd0);
    cyc(8'h00, 8'hFF, 0, 0);
    chk("t6.late_irq", 32'(irq), 32'd1);
    chk("t6.late_id", 32'(irq_id), 32'd1);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] s, m;
      logic a, e;
      s = 8'($urandom) & 8'($urandom) & 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      a = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      e = (m_stk.size() > 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
      cyc(s, m, a, e);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
